seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 43 ++++
 rtl/seg_glyph.sv | 31 +++
 rtl/seven_seg_scanner.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment positions, hex glyphs and scan state encoding
package seven_seg_pkg;

    // Bit positions within the active-low seg_data bus
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    // Active-high glyphs, bit 6 = a ... bit 0 = g
    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    typedef enum logic [1:0] {
        SCAN_DEAD = 2'd0,
        SCAN_ON   = 2'd1,
        SCAN_DARK = 2'd2
    } scan_state_e;

    function automatic logic [7:0] seg_pack(input logic [6:0] glyph, input logic dp_on);
        logic [7:0] seg;
        seg = SEG_ALL_OFF;
        seg[SEG_A_BIT:SEG_G_BIT] = ~glyph;
        seg[SEG_DP_BIT] = ~dp_on;
        return seg;
    endfunction

endpackage

// File: rtl/seg_glyph.sv
// rtl/seg_glyph.sv - combinational hex nibble to a..g glyph decoder
module seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_0;
        case (nibble_i)
            4'h0: glyph_o = GLYPH_0;
            4'h1: glyph_o = GLYPH_1;
            4'h2: glyph_o = GLYPH_2;
            4'h3: glyph_o = GLYPH_3;
            4'h4: glyph_o = GLYPH_4;
            4'h5: glyph_o = GLYPH_5;
            4'h6: glyph_o = GLYPH_6;
            4'h7: glyph_o = GLYPH_7;
            4'h8: glyph_o = GLYPH_8;
            4'h9: glyph_o = GLYPH_9;
            4'hA: glyph_o = GLYPH_A;
            4'hB: glyph_o = GLYPH_B;
            4'hC: glyph_o = GLYPH_C;
            4'hD: glyph_o = GLYPH_D;
            4'hE: glyph_o = GLYPH_E;
            default: glyph_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed seven-segment scanner with dimming, blink and zero blanking
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_CNT  = 16384,
    parameter int DEAD_CYCLES  = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    segclk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   seg_en,
    output logic [7:0]              seg_data,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_CNT);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FRM_W-1:0]        fcnt_q, fcnt_d;
    logic                    blink_q, blink_d;

    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   bm_q, bm_d;
    logic                    lz_q, lz_d;
    logic [3:0]              bri_q, bri_d;

    logic [NUM_DIGITS-1:0]   seg_en_q, seg_en_d;
    logic [7:0]              seg_data_q, seg_data_d;
    logic                    tick_q, tick_d;

    logic                    frame_start, cnt_last, idx_last;
    logic [31:0]             on_prod, on_len, cnt_ext;
    scan_state_e             slot_state;
    logic [NUM_DIGITS-1:0]   lz_hide;
    logic                    above_zero;
    logic [3:0]              digit_nib;
    logic [6:0]              digit_glyph;

    assign frame_start = enable && (cnt_q == '0) && (idx_q == '0);
    assign cnt_last    = (cnt_q == CNT_W'(REFRESH_CNT - 1));
    assign idx_last    = (idx_q == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge segclk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            fcnt_q     <= '0;
            blink_q    <= 1'b0;
            data_q     <= '0;
            dp_q       <= '0;
            bm_q       <= '0;
            lz_q       <= 1'b0;
            bri_q      <= '0;
            seg_en_q   <= '0;
            seg_data_q <= SEG_ALL_OFF;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            blink_q    <= blink_d;
            data_q     <= data_d;
            dp_q       <= dp_d;
            bm_q       <= bm_d;
            lz_q       <= lz_d;
            bri_q      <= bri_d;
            seg_en_q   <= seg_en_d;
            seg_data_q <= seg_data_d;
            tick_q     <= tick_d;
        end
    end

    // Position advance; blink phase flips when the last slot of a frame retires
    always_comb begin
        cnt_d   = '0;
        idx_d   = '0;
        fcnt_d  = '0;
        blink_d = 1'b0;
        if (enable) begin
            cnt_d   = cnt_last ? '0 : cnt_q + CNT_W'(1);
            idx_d   = idx_q;
            fcnt_d  = fcnt_q;
            blink_d = blink_q;
            if (cnt_last) begin
                idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
                if (idx_last) begin
                    if (fcnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        blink_d = ~blink_q;
                    end else begin
                        fcnt_d = fcnt_q + FRM_W'(1);
                    end
                end
            end
        end
    end

    // Shadow path feeds the output decode directly so the frame-start slot sees fresh values
    always_comb begin
        data_d = data_q;
        dp_d   = dp_q;
        bm_d   = bm_q;
        lz_d   = lz_q;
        bri_d  = bri_q;
        if (frame_start) begin
            data_d = data;
            dp_d   = dp_mask;
            bm_d   = blink_mask;
            lz_d   = lz_blank;
            bri_d  = brightness;
        end
    end

    always_comb begin
        cnt_ext = 32'(cnt_q);
        on_prod = 32'(REFRESH_CNT - DEAD_CYCLES) * (32'(bri_d) + 32'd1);
        on_len  = on_prod >> 4;
        if (on_len == 32'd0) begin
            on_len = 32'd1;
        end
        if (cnt_ext < 32'(DEAD_CYCLES)) begin
            slot_state = SCAN_DEAD;
        end else if (cnt_ext < 32'(DEAD_CYCLES) + on_len) begin
            slot_state = SCAN_ON;
        end else begin
            slot_state = SCAN_DARK;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        lz_hide    = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero = above_zero && (data_d[4*i +: 4] == 4'h0);
            lz_hide[i] = above_zero && (i != 0);
        end
    end

    assign digit_nib = data_d[{idx_q, 2'b00} +: 4];

    seg_glyph u_glyph (
        .nibble_i (digit_nib),
        .glyph_o  (digit_glyph)
    );

    always_comb begin
        seg_en_d   = '0;
        seg_data_d = SEG_ALL_OFF;
        tick_d     = frame_start;
        if (enable && slot_state == SCAN_ON) begin
            seg_en_d[idx_q] = 1'b1;
            if (blink_q && bm_d[idx_q]) begin
                seg_data_d = SEG_ALL_OFF;
            end else if (lz_d && lz_hide[idx_q]) begin
                seg_data_d = seg_pack(7'h00, dp_d[idx_q]);
            end else begin
                seg_data_d = seg_pack(digit_glyph, dp_d[idx_q]);
            end
        end
    end

    assign seg_en     = seg_en_q;
    assign seg_data   = seg_data_q;
    assign frame_tick = tick_q;

endmodule
